// File: rtl/tbus_arbiter_if.sv
// Bundle of the two tbus requester channels and the downstream memory port.
// The arbiter connects through the slave modport; the environment uses master.
interface tbus_arbiter_if #(
   parameter int ADDR_W   = 64,
   parameter int DATA_W   = 64,
   parameter int MASK_W   = 64,
   parameter int OPTYPE_W = 2
) ();
   logic                load2arb_tbus_index_valid;
   logic                load2arb_tbus_index_ready;
   logic [ADDR_W-1:0]   load2arb_tbus_index;
   logic [DATA_W-1:0]   load2arb_tbus_write_data;
   logic [MASK_W-1:0]   load2arb_tbus_write_mask;
   logic [OPTYPE_W-1:0] load2arb_tbus_operation_type;
   logic [DATA_W-1:0]   load2arb_tbus_read_data;
   logic                load2arb_tbus_operation_done;
   logic                load2arb_flush_valid;

   logic                sq2arb_tbus_index_valid;
   logic                sq2arb_tbus_index_ready;
   logic [ADDR_W-1:0]   sq2arb_tbus_index;
   logic [DATA_W-1:0]   sq2arb_tbus_write_data;
   logic [MASK_W-1:0]   sq2arb_tbus_write_mask;
   logic [OPTYPE_W-1:0] sq2arb_tbus_operation_type;
   logic [DATA_W-1:0]   sq2arb_tbus_read_data;
   logic                sq2arb_tbus_operation_done;

   logic                arb2mem_req_valid;
   logic                arb2mem_req_ready;
   logic [ADDR_W-1:0]   arb2mem_req_addr;
   logic [DATA_W-1:0]   arb2mem_req_wdata;
   logic [MASK_W-1:0]   arb2mem_req_wmask;
   logic [OPTYPE_W-1:0] arb2mem_req_optype;
   logic                mem2arb_resp_valid;
   logic [DATA_W-1:0]   mem2arb_resp_data;

   modport slave (
      input  load2arb_tbus_index_valid, load2arb_tbus_index, load2arb_tbus_write_data,
             load2arb_tbus_write_mask, load2arb_tbus_operation_type, load2arb_flush_valid,
      output load2arb_tbus_index_ready, load2arb_tbus_read_data, load2arb_tbus_operation_done,
      input  sq2arb_tbus_index_valid, sq2arb_tbus_index, sq2arb_tbus_write_data,
             sq2arb_tbus_write_mask, sq2arb_tbus_operation_type,
      output sq2arb_tbus_index_ready, sq2arb_tbus_read_data, sq2arb_tbus_operation_done,
      output arb2mem_req_valid, arb2mem_req_addr, arb2mem_req_wdata, arb2mem_req_wmask,
             arb2mem_req_optype,
      input  arb2mem_req_ready, mem2arb_resp_valid, mem2arb_resp_data
   );

   modport master (
      output load2arb_tbus_index_valid, load2arb_tbus_index, load2arb_tbus_write_data,
             load2arb_tbus_write_mask, load2arb_tbus_operation_type, load2arb_flush_valid,
      input  load2arb_tbus_index_ready, load2arb_tbus_read_data, load2arb_tbus_operation_done,
      output sq2arb_tbus_index_valid, sq2arb_tbus_index, sq2arb_tbus_write_data,
             sq2arb_tbus_write_mask, sq2arb_tbus_operation_type,
      input  sq2arb_tbus_index_ready, sq2arb_tbus_read_data, sq2arb_tbus_operation_done,
      input  arb2mem_req_valid, arb2mem_req_addr, arb2mem_req_wdata, arb2mem_req_wmask,
             arb2mem_req_optype,
      output arb2mem_req_ready, mem2arb_resp_valid, mem2arb_resp_data
   );
endinterface

// File: rtl/tbus_arbiter.sv
// Round-robin tbus responder: arbitrates the load and store-queue channels onto one
// memory port with a single outstanding transaction and load-flush squashing.
module tbus_arbiter #(
   parameter int ADDR_W   = 64,
   parameter int DATA_W   = 64,
   parameter int MASK_W   = 64,
   parameter int OPTYPE_W = 2
) (
   input  logic           clock,
   input  logic           reset_n,
   tbus_arbiter_if.slave  bus
);
   localparam logic CH_LOAD = 1'b0;
   localparam logic CH_SQ   = 1'b1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t              state_reg, state_next;
   logic                owner_reg, owner_next;
   logic                last_grant_reg, last_grant_next;
   logic                drop_reg, drop_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [DATA_W-1:0]   wdata_reg, wdata_next;
   logic [MASK_W-1:0]   wmask_reg, wmask_next;
   logic [OPTYPE_W-1:0] optype_reg, optype_next;

   logic                load_offer, sq_offer;
   logic                grant_load, grant_sq;
   logic                flush_owned;
   logic [1:0]          done_set;

   // A flushed load offer never competes; on conflict the channel not served last wins.
   assign load_offer  = bus.load2arb_tbus_index_valid && !bus.load2arb_flush_valid;
   assign sq_offer    = bus.sq2arb_tbus_index_valid;
   assign grant_load  = load_offer && (!sq_offer || (last_grant_reg == CH_SQ));
   assign grant_sq    = sq_offer && (!load_offer || (last_grant_reg == CH_LOAD));
   assign flush_owned = bus.load2arb_flush_valid && (owner_reg == CH_LOAD);

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_grant_next = last_grant_reg;
      drop_next       = drop_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      wmask_next      = wmask_reg;
      optype_next     = optype_reg;
      done_set        = 2'b00;

      case (state_reg)
         IDLE: begin
            if (grant_load || grant_sq) begin
               state_next      = REQ;
               owner_next      = grant_sq ? CH_SQ : CH_LOAD;
               last_grant_next = grant_sq ? CH_SQ : CH_LOAD;
               addr_next       = grant_sq ? bus.sq2arb_tbus_index          : bus.load2arb_tbus_index;
               wdata_next      = grant_sq ? bus.sq2arb_tbus_write_data     : bus.load2arb_tbus_write_data;
               wmask_next      = grant_sq ? bus.sq2arb_tbus_write_mask     : bus.load2arb_tbus_write_mask;
               optype_next     = grant_sq ? bus.sq2arb_tbus_operation_type : bus.load2arb_tbus_operation_type;
            end
         end
         REQ: begin
            if (flush_owned) begin
               state_next = IDLE;
            end else if (bus.arb2mem_req_ready) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            // Already accepted downstream: a flush can only suppress the completion.
            if (bus.mem2arb_resp_valid) begin
               state_next = IDLE;
               drop_next  = 1'b0;
               if (!(drop_reg || flush_owned)) begin
                  done_set[owner_reg] = 1'b1;
               end
            end else if (flush_owned) begin
               drop_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         owner_reg      <= CH_LOAD;
         last_grant_reg <= CH_SQ;
         drop_reg       <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         wmask_reg      <= '0;
         optype_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_grant_reg <= last_grant_next;
         drop_reg       <= drop_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         wmask_reg      <= wmask_next;
         optype_reg     <= optype_next;
      end
   end

   // Per-channel completion: done pulses for one cycle, read data holds until the next one.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         logic              done_reg;
         logic [DATA_W-1:0] read_data_reg;

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               done_reg      <= 1'b0;
               read_data_reg <= '0;
            end else begin
               done_reg <= done_set[gi];
               if (done_set[gi]) begin
                  read_data_reg <= bus.mem2arb_resp_data;
               end
            end
         end
      end
   endgenerate

   // Ready is gated by reset_n so every output reads 0 while reset is held.
   assign bus.load2arb_tbus_index_ready    = reset_n && (state_reg == IDLE) && grant_load;
   assign bus.sq2arb_tbus_index_ready      = reset_n && (state_reg == IDLE) && grant_sq;
   assign bus.load2arb_tbus_operation_done = g_chan[0].done_reg;
   assign bus.load2arb_tbus_read_data      = g_chan[0].read_data_reg;
   assign bus.sq2arb_tbus_operation_done   = g_chan[1].done_reg;
   assign bus.sq2arb_tbus_read_data        = g_chan[1].read_data_reg;

   assign bus.arb2mem_req_valid  = (state_reg == REQ) && !flush_owned;
   assign bus.arb2mem_req_addr   = addr_reg;
   assign bus.arb2mem_req_wdata  = wdata_reg;
   assign bus.arb2mem_req_wmask  = wmask_reg;
   assign bus.arb2mem_req_optype = optype_reg;
endmodule

// File: tb/tb_tbus_arbiter.sv
// Scenario bench for tbus_arbiter: per-scenario tasks plus a completion scoreboard
// that matches every done pulse against the queue of expected completions.
module tb_tbus_arbiter;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   compared = 0;
   int   mismatched = 0;

   typedef struct {
      logic        ch;
      logic [63:0] data;
   } exp_t;
   exp_t        exp_q[$];
   exp_t        mon_e;
   logic        mon_ch;
   logic [63:0] mon_data;
   logic [63:0] last_load_data = 64'h0;
   logic        lg_model = 1'b1;

   tbus_arbiter_if #(.ADDR_W(64), .DATA_W(64), .MASK_W(64), .OPTYPE_W(2)) bus ();

   tbus_arbiter #(.ADDR_W(64), .DATA_W(64), .MASK_W(64), .OPTYPE_W(2)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   function automatic logic [10:0] outs_vec();
      return {bus.load2arb_tbus_index_ready, bus.sq2arb_tbus_index_ready,
              bus.load2arb_tbus_operation_done, bus.sq2arb_tbus_operation_done,
              bus.arb2mem_req_valid, |bus.arb2mem_req_addr, |bus.arb2mem_req_wdata,
              |bus.arb2mem_req_wmask, |bus.arb2mem_req_optype,
              |bus.load2arb_tbus_read_data, |bus.sq2arb_tbus_read_data};
   endfunction

   // Scoreboard: every done pulse must match the oldest expected completion.
   always @(negedge clock) begin
      if (reset_n && (bus.load2arb_tbus_operation_done || bus.sq2arb_tbus_operation_done)) begin
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL scoreboard_unexpected_done: load_done=%0b sq_done=%0b, required no completion",
                     bus.load2arb_tbus_operation_done, bus.sq2arb_tbus_operation_done);
         end else begin
            mon_e    = exp_q.pop_front();
            mon_ch   = bus.sq2arb_tbus_operation_done;
            mon_data = mon_ch ? bus.sq2arb_tbus_read_data : bus.load2arb_tbus_read_data;
            if ((bus.load2arb_tbus_operation_done && bus.sq2arb_tbus_operation_done) ||
                mon_ch !== mon_e.ch || mon_data !== mon_e.data) begin
               mismatched++;
               $display("FAIL scoreboard_done: ch=%0d data=%h, required ch=%0d data=%h",
                        mon_ch, mon_data, mon_e.ch, mon_e.data);
            end else begin
               $display("txn done ch=%0d data=%h", mon_ch, mon_data);
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.load2arb_tbus_index_valid    = 1'b0;
      bus.load2arb_tbus_index          = '0;
      bus.load2arb_tbus_write_data     = '0;
      bus.load2arb_tbus_write_mask     = '0;
      bus.load2arb_tbus_operation_type = '0;
      bus.load2arb_flush_valid         = 1'b0;
      bus.sq2arb_tbus_index_valid      = 1'b0;
      bus.sq2arb_tbus_index            = '0;
      bus.sq2arb_tbus_write_data       = '0;
      bus.sq2arb_tbus_write_mask       = '0;
      bus.sq2arb_tbus_operation_type   = '0;
      bus.arb2mem_req_ready            = 1'b0;
      bus.mem2arb_resp_valid           = 1'b0;
      bus.mem2arb_resp_data            = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      bus.load2arb_tbus_index_valid = 1'b1;
      bus.sq2arb_tbus_index_valid   = 1'b1;
      repeat (2) cycle();
      @(negedge clock);
      compared++;
      if (outs_vec() !== 11'b0) begin
         mismatched++;
         $display("FAIL reset_outputs: got %b, required 0", outs_vec());
      end
      @(posedge clock);
      #2;
      reset_n = 1'b1;
      bus.load2arb_tbus_index_valid = 1'b0;
      bus.sq2arb_tbus_index_valid   = 1'b0;
      @(negedge clock);
      compared++;
      if (outs_vec() !== 11'b0) begin
         mismatched++;
         $display("FAIL reset_idle_outputs: got %b, required 0", outs_vec());
      end
      cycle();
      $display("txn reset done");
   endtask

   task automatic test_back_to_back();
      logic        exp_ch;
      logic [63:0] exp_addr;
      logic [63:0] rdata;
      for (int i = 0; i < 4; i++) begin
         bus.load2arb_tbus_index_valid    = 1'b1;
         bus.load2arb_tbus_index          = 64'hA0 + 64'(i);
         bus.load2arb_tbus_operation_type = 2'd0;
         bus.sq2arb_tbus_index_valid      = 1'b1;
         bus.sq2arb_tbus_index            = 64'hB0 + 64'(i);
         bus.sq2arb_tbus_write_data       = 64'h5500 + 64'(i);
         bus.sq2arb_tbus_write_mask       = 64'hFFFF;
         bus.sq2arb_tbus_operation_type   = 2'd1;
         exp_ch   = ~lg_model;
         exp_addr = exp_ch ? (64'hB0 + 64'(i)) : (64'hA0 + 64'(i));
         @(negedge clock);
         compared++;
         if ({bus.load2arb_tbus_index_ready, bus.sq2arb_tbus_index_ready} !== (exp_ch ? 2'b01 : 2'b10)) begin
            mismatched++;
            $display("FAIL rr_grant[%0d]: ready load/sq=%b%b, required grant ch=%0d", i,
                     bus.load2arb_tbus_index_ready, bus.sq2arb_tbus_index_ready, exp_ch);
         end
         cycle();
         lg_model = exp_ch;
         bus.arb2mem_req_ready = 1'b1;
         @(negedge clock);
         compared++;
         if (bus.arb2mem_req_valid !== 1'b1 || bus.arb2mem_req_addr !== exp_addr ||
             bus.load2arb_tbus_index_ready !== 1'b0 || bus.sq2arb_tbus_index_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL rr_req[%0d]: valid=%0b addr=%h readies=%b%b, required valid=1 addr=%h readies=00",
                     i, bus.arb2mem_req_valid, bus.arb2mem_req_addr,
                     bus.load2arb_tbus_index_ready, bus.sq2arb_tbus_index_ready, exp_addr);
         end
         cycle();
         bus.arb2mem_req_ready  = 1'b0;
         rdata                  = 64'h1000 + 64'(i);
         bus.mem2arb_resp_valid = 1'b1;
         bus.mem2arb_resp_data  = rdata;
         exp_q.push_back('{ch: exp_ch, data: rdata});
         if (exp_ch == 1'b0) last_load_data = rdata;
         cycle();
         bus.mem2arb_resp_valid = 1'b0;
      end
      idle_inputs();
      cycle();
   endtask

   task automatic test_single_load();
      logic [63:0] rdata = 64'hDEAD_BEEF_0123_4567;
      bus.load2arb_tbus_index_valid    = 1'b1;
      bus.load2arb_tbus_index          = 64'h8000_0010;
      bus.load2arb_tbus_operation_type = 2'd0;
      @(negedge clock);
      compared++;
      if (bus.load2arb_tbus_index_ready !== 1'b1 || bus.sq2arb_tbus_index_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL load_ready: load=%0b sq=%0b, required load=1 sq=0",
                  bus.load2arb_tbus_index_ready, bus.sq2arb_tbus_index_ready);
      end
      cycle();
      lg_model = 1'b0;
      bus.load2arb_tbus_index_valid = 1'b0;
      bus.arb2mem_req_ready = 1'b1;
      @(negedge clock);
      compared++;
      if (bus.arb2mem_req_valid !== 1'b1 || bus.arb2mem_req_addr !== 64'h8000_0010 ||
          bus.arb2mem_req_optype !== 2'd0) begin
         mismatched++;
         $display("FAIL load_req: valid=%0b addr=%h op=%0d, required valid=1 addr=80000010 op=0",
                  bus.arb2mem_req_valid, bus.arb2mem_req_addr, bus.arb2mem_req_optype);
      end
      cycle();
      bus.arb2mem_req_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         compared++;
         if (bus.arb2mem_req_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL load_wait_valid[%0d]: req_valid=%0b, required 0", k, bus.arb2mem_req_valid);
         end
         cycle();
      end
      bus.mem2arb_resp_valid = 1'b1;
      bus.mem2arb_resp_data  = rdata;
      exp_q.push_back('{ch: 1'b0, data: rdata});
      cycle();
      bus.mem2arb_resp_valid = 1'b0;
      @(negedge clock);
      compared++;
      if (bus.load2arb_tbus_operation_done !== 1'b1 || bus.sq2arb_tbus_operation_done !== 1'b0) begin
         mismatched++;
         $display("FAIL load_done_latency: load_done=%0b sq_done=%0b, required 1/0",
                  bus.load2arb_tbus_operation_done, bus.sq2arb_tbus_operation_done);
      end
      cycle();
      @(negedge clock);
      compared++;
      if (bus.load2arb_tbus_operation_done !== 1'b0 || bus.load2arb_tbus_read_data !== rdata) begin
         mismatched++;
         $display("FAIL load_hold: done=%0b data=%h, required done=0 data=%h",
                  bus.load2arb_tbus_operation_done, bus.load2arb_tbus_read_data, rdata);
      end
      last_load_data = rdata;
      cycle();
   endtask

   task automatic test_store_write_stall();
      logic [63:0] rdata = 64'h5A5A_0000_0000_00FF;
      bus.sq2arb_tbus_index_valid    = 1'b1;
      bus.sq2arb_tbus_index          = 64'h100;
      bus.sq2arb_tbus_write_data     = 64'hFF;
      bus.sq2arb_tbus_write_mask     = 64'hFF;
      bus.sq2arb_tbus_operation_type = 2'd1;
      @(negedge clock);
      compared++;
      if (bus.sq2arb_tbus_index_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL sq_ready: got %0b, required 1", bus.sq2arb_tbus_index_ready);
      end
      cycle();
      lg_model = 1'b1;
      bus.sq2arb_tbus_index_valid    = 1'b0;
      bus.sq2arb_tbus_index          = 64'(($urandom()));
      bus.sq2arb_tbus_write_data     = 64'hBAD0_BAD0;
      bus.sq2arb_tbus_write_mask     = 64'h0F0F;
      bus.sq2arb_tbus_operation_type = 2'd0;
      for (int k = 0; k < 6; k++) begin
         if (k == 5) bus.arb2mem_req_ready = 1'b1;
         @(negedge clock);
         compared++;
         if (bus.arb2mem_req_valid !== 1'b1 || bus.arb2mem_req_addr !== 64'h100 ||
             bus.arb2mem_req_wdata !== 64'hFF || bus.arb2mem_req_wmask !== 64'hFF ||
             bus.arb2mem_req_optype !== 2'd1) begin
            mismatched++;
            $display("FAIL sq_stall_stable[%0d]: v=%0b a=%h d=%h m=%h op=%0d, required v=1 a=100 d=ff m=ff op=1",
                     k, bus.arb2mem_req_valid, bus.arb2mem_req_addr, bus.arb2mem_req_wdata,
                     bus.arb2mem_req_wmask, bus.arb2mem_req_optype);
         end
         cycle();
      end
      bus.arb2mem_req_ready  = 1'b0;
      bus.mem2arb_resp_valid = 1'b1;
      bus.mem2arb_resp_data  = rdata;
      exp_q.push_back('{ch: 1'b1, data: rdata});
      cycle();
      bus.mem2arb_resp_valid = 1'b0;
      @(negedge clock);
      compared++;
      if (bus.sq2arb_tbus_operation_done !== 1'b1) begin
         mismatched++;
         $display("FAIL sq_done: got %0b, required 1", bus.sq2arb_tbus_operation_done);
      end
      idle_inputs();
      cycle();
   endtask

   task automatic test_flush_in_req();
      bus.load2arb_tbus_index_valid = 1'b1;
      bus.load2arb_tbus_index       = 64'h200;
      bus.load2arb_flush_valid      = 1'b1;
      @(negedge clock);
      compared++;
      if (bus.load2arb_tbus_index_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL flushed_offer_ready: got %0b, required 0", bus.load2arb_tbus_index_ready);
      end
      cycle();
      bus.load2arb_flush_valid = 1'b0;
      cycle();
      bus.load2arb_tbus_index_valid = 1'b0;
      lg_model = 1'b0;
      @(negedge clock);
      compared++;
      if (bus.arb2mem_req_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL flush_req_valid_before: got %0b, required 1", bus.arb2mem_req_valid);
      end
      cycle();
      bus.load2arb_flush_valid       = 1'b1;
      bus.arb2mem_req_ready          = 1'b1;
      bus.sq2arb_tbus_index_valid    = 1'b1;
      bus.sq2arb_tbus_index          = 64'h300;
      bus.sq2arb_tbus_write_data     = 64'h33;
      bus.sq2arb_tbus_write_mask     = 64'hFF;
      bus.sq2arb_tbus_operation_type = 2'd1;
      @(negedge clock);
      compared++;
      if (bus.arb2mem_req_valid !== 1'b0 || bus.sq2arb_tbus_index_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL flush_req_drop: req_valid=%0b sq_ready=%0b, required 0/0",
                  bus.arb2mem_req_valid, bus.sq2arb_tbus_index_ready);
      end
      cycle();
      bus.load2arb_flush_valid = 1'b0;
      bus.arb2mem_req_ready    = 1'b0;
      @(negedge clock);
      compared++;
      if (bus.sq2arb_tbus_index_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL flush_next_sq_grant: sq_ready=%0b, required 1", bus.sq2arb_tbus_index_ready);
      end
      cycle();
      lg_model = 1'b1;
      bus.sq2arb_tbus_index_valid = 1'b0;
      bus.arb2mem_req_ready       = 1'b1;
      @(negedge clock);
      compared++;
      if (bus.arb2mem_req_valid !== 1'b1 || bus.arb2mem_req_addr !== 64'h300) begin
         mismatched++;
         $display("FAIL flush_sq_req: valid=%0b addr=%h, required 1/300",
                  bus.arb2mem_req_valid, bus.arb2mem_req_addr);
      end
      cycle();
      bus.arb2mem_req_ready  = 1'b0;
      bus.mem2arb_resp_valid = 1'b1;
      bus.mem2arb_resp_data  = 64'h77;
      exp_q.push_back('{ch: 1'b1, data: 64'h77});
      cycle();
      idle_inputs();
      cycle();
   endtask

   task automatic test_flush_in_wait();
      bus.load2arb_tbus_index_valid = 1'b1;
      bus.load2arb_tbus_index       = 64'h400;
      cycle();
      lg_model = 1'b0;
      bus.load2arb_tbus_index_valid = 1'b0;
      bus.arb2mem_req_ready = 1'b1;
      cycle();
      bus.arb2mem_req_ready    = 1'b0;
      bus.load2arb_flush_valid = 1'b1;
      cycle();
      bus.load2arb_flush_valid = 1'b0;
      cycle();
      bus.mem2arb_resp_valid = 1'b1;
      bus.mem2arb_resp_data  = 64'h1234;
      cycle();
      bus.mem2arb_resp_valid = 1'b0;
      bus.sq2arb_tbus_index_valid = 1'b1;
      @(negedge clock);
      compared++;
      if (bus.load2arb_tbus_operation_done !== 1'b0 || bus.load2arb_tbus_read_data !== last_load_data ||
          bus.sq2arb_tbus_index_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL flush_wait_drop: done=%0b data=%h idle_ready=%0b, required 0/%h/1",
                  bus.load2arb_tbus_operation_done, bus.load2arb_tbus_read_data,
                  bus.sq2arb_tbus_index_ready, last_load_data);
      end
      bus.sq2arb_tbus_index_valid = 1'b0;
      cycle();
      bus.load2arb_tbus_index_valid = 1'b1;
      bus.load2arb_tbus_index       = 64'h500;
      cycle();
      bus.load2arb_tbus_index_valid = 1'b0;
      bus.arb2mem_req_ready = 1'b1;
      cycle();
      bus.arb2mem_req_ready  = 1'b0;
      bus.mem2arb_resp_valid = 1'b1;
      bus.mem2arb_resp_data  = 64'hCAFE;
      exp_q.push_back('{ch: 1'b0, data: 64'hCAFE});
      cycle();
      bus.mem2arb_resp_valid = 1'b0;
      @(negedge clock);
      compared++;
      if (bus.load2arb_tbus_operation_done !== 1'b1) begin
         mismatched++;
         $display("FAIL drop_cleared_done: got %0b, required 1", bus.load2arb_tbus_operation_done);
      end
      last_load_data = 64'hCAFE;
      cycle();
   endtask

   task automatic test_reset_mid();
      bus.load2arb_tbus_index_valid = 1'b1;
      bus.load2arb_tbus_index       = 64'h600;
      cycle();
      bus.load2arb_tbus_index_valid = 1'b0;
      bus.arb2mem_req_ready = 1'b1;
      cycle();
      bus.arb2mem_req_ready = 1'b0;
      bus.load2arb_tbus_index_valid = 1'b1;
      bus.sq2arb_tbus_index_valid   = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      compared++;
      if (outs_vec() !== 11'b0) begin
         mismatched++;
         $display("FAIL reset_async_outputs: got %b, required 0", outs_vec());
      end
      @(posedge clock);
      #2;
      bus.load2arb_tbus_index_valid = 1'b0;
      bus.sq2arb_tbus_index_valid   = 1'b0;
      reset_n = 1'b1;
      bus.mem2arb_resp_valid = 1'b1;
      bus.mem2arb_resp_data  = 64'h9999;
      cycle();
      bus.mem2arb_resp_valid = 1'b0;
      bus.load2arb_tbus_index_valid = 1'b1;
      bus.sq2arb_tbus_index_valid   = 1'b1;
      @(negedge clock);
      compared++;
      if (bus.load2arb_tbus_index_ready !== 1'b1 || bus.sq2arb_tbus_index_ready !== 1'b0 ||
          bus.load2arb_tbus_read_data !== 64'h0) begin
         mismatched++;
         $display("FAIL reset_first_grant: load=%0b sq=%0b rd=%h, required 1/0/0",
                  bus.load2arb_tbus_index_ready, bus.sq2arb_tbus_index_ready, bus.load2arb_tbus_read_data);
      end
      idle_inputs();
      repeat (3) cycle();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_single_load();
      test_store_write_stall();
      test_flush_in_req();
      test_flush_in_wait();
      test_reset_mid();
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: %0d completions outstanding, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
